// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// (read-only) and the load/store unit (read/write). The LSU has fixed priority,
// but fetch is guaranteed a grant after MAX_LS_STREAK consecutive LSU grants
// while it is waiting. Each transaction is a req/ready handshake on the memory
// side, with an optional timeout that aborts a hung access and flags bus_err.
module mem_port_arbiter #(
    parameter int XLEN          = 32,
    parameter int MAX_LS_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [3:0]      ls_wmask,
    output logic            ls_ready,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
    localparam logic [CW-1:0] TCNT_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t          state_q;
    logic [SW-1:0]   streak_q;
    logic [CW-1:0]   tcnt_q;
    logic            if_ready_q;
    logic            ls_ready_q;
    logic            bus_err_q;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] ls_rdata_q;
    logic            mem_valid_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [3:0]      mem_wmask_q;

    logic            grant_ls_d;
    logic            grant_if_d;
    logic [SW-1:0]   streak_d;
    logic            timeout_hit_d;
    logic [XLEN-1:0] resp_data_d;

    // Arbitration decision, streak bookkeeping and completion data selection.
    always_comb begin
        grant_ls_d    = ls_req && (!if_req || (streak_q < STREAK_MAX));
        grant_if_d    = !grant_ls_d && if_req;
        timeout_hit_d = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);
        // An aborted read returns zero rather than whatever is on the bus.
        if (mem_ready) begin
            resp_data_d = mem_rdata;
        end else begin
            resp_data_d = '0;
        end
        // Only LSU grants that overtake a waiting fetch count toward the streak.
        if (grant_ls_d) begin
            if (if_req && (streak_q < STREAK_MAX)) begin
                streak_d = streak_q + 1'b1;
            end else begin
                streak_d = streak_q;
            end
        end else if (grant_if_d) begin
            streak_d = '0;
        end else begin
            streak_d = streak_q;
        end
    end

    // Transaction sequencer: grant in IDLE, wait for ready/timeout in BUSY, one-cycle RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tcnt_q      <= '0;
            if_ready_q  <= 1'b0;
            ls_ready_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= 4'b0000;
        end else begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    if (grant_ls_d) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= ls_we;
                        mem_addr_q  <= ls_addr;
                        mem_wdata_q <= ls_wdata;
                        mem_wmask_q <= ls_we ? ls_wmask : 4'b0000;
                        tcnt_q      <= '0;
                        state_q     <= BUSY_LS;
                    end else if (grant_if_d) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wmask_q <= 4'b0000;
                        tcnt_q      <= '0;
                        state_q     <= BUSY_IF;
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    // mem_ready takes precedence over a timeout on the same edge.
                    if (mem_ready || timeout_hit_d) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wmask_q <= 4'b0000;
                        bus_err_q   <= !mem_ready;
                        state_q     <= RESP;
                        if (state_q == BUSY_IF) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= resp_data_d;
                        end else begin
                            ls_ready_q <= 1'b1;
                            if (!mem_we_q) begin
                                ls_rdata_q <= resp_data_d;
                            end
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign ls_ready  = ls_ready_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (read-only) and the execute-stage load/store path (read/write).
- Arbitrates with fixed LSU priority and an anti-starvation streak limit for fetch.
- Sequences each transaction through a req/ready handshake on the memory side, with a bus timeout.
- Execute consumes `ls_rdata` as its `memData` input; fetch consumes `if_rdata` as the instruction word.

Parameters:
- XLEN, 32, data and address width
- MAX_LS_STREAK, 4, consecutive LSU grants allowed while fetch waits (≥1)
- TIMEOUT, 64, cycles in BUSY without `mem_ready` before abort; 0 disables the timeout

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held with `if_addr` stable until `if_ready`
- if_addr  input  XLEN  fetch address
- if_ready  output  1  one-cycle completion pulse to fetch
- if_rdata  output  XLEN  fetched word, valid while `if_ready`=1, held afterwards
- ls_req  input  1  load/store request; held with all `ls_*` fields stable until `ls_ready`
- ls_we  input  1  1=store, 0=load
- ls_addr  input  XLEN  load/store address
- ls_wdata  input  XLEN  store data
- ls_wmask  input  4  store byte enables; bit3 = bits[31:24]
- ls_ready  output  1  one-cycle completion pulse to LSU
- ls_rdata  output  XLEN  load data; updated only on loads, held otherwise
- mem_valid  output  1  memory request active
- mem_we  output  1  write enable
- mem_addr  output  XLEN  address
- mem_wdata  output  XLEN  write data
- mem_wmask  output  4  byte enables; 0 on reads
- mem_ready  input  1  memory completion; sampled only while `mem_valid`=1
- mem_rdata  input  XLEN  read data, valid with `mem_ready`
- bus_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- State machine: IDLE, BUSY_IF, BUSY_LS, RESP.
- Reset (synchronous): state=IDLE; streak=0; timeout counter=0; all outputs 0, including both rdata registers. Reset wins over every other event.
- Reset mid-transaction: `mem_valid`=0 after the reset edge, no ready pulse, transaction abandoned.
- All outputs are registered; no combinational input-to-output paths.
- IDLE arbitration at each posedge:
  - Grant LSU if `ls_req` && (!`if_req` || streak<MAX_LS_STREAK); else grant fetch if `if_req`; else stay in IDLE.
  - On a grant: latch addr/we/wdata/wmask into the `mem_*` registers, set `mem_valid`=1, go to BUSY_IF or BUSY_LS, clear the timeout counter.
  - For fetch grants: `mem_we`=0, `mem_wmask`=0.
- Streak counter:
  - Cleared on any fetch grant.
  - Incremented, saturating at MAX_LS_STREAK, on an LSU grant while `if_req`=1.
  - Unchanged on an LSU grant while `if_req`=0.
- BUSY state at each posedge:
  - If `mem_ready`: `mem_valid`=0; the owner's ready=1; the owner's rdata=`mem_rdata` (reads only); go to RESP.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: `mem_valid`=0; the owner's ready=1; the owner's rdata=0 (reads only); `bus_err`=1; go to RESP.
  - Else: increment the counter.
  - `mem_ready` and timeout on the same edge: `mem_ready` wins, no `bus_err`.
- RESP: ready, `bus_err` → 0; go to IDLE. Requests are not sampled in RESP, so a stale held request is never re-granted.
- Latency with `mem_ready` returned in the first BUSY cycle:
  - `mem_valid` is high 1 cycle after the request is sampled.
  - Ready pulses 2 cycles after the request is sampled.
  - The next grant is sampled no earlier than 2 cycles after the ready pulse.
- Fields other than `mem_valid`/`mem_we`/`mem_wmask` hold their last value when idle.
- `mem_ready` while not BUSY: ignored.
- Requester deasserting req while granted: the transaction still completes and pulses ready.
- Ready/`bus_err` are never high for more than one cycle. `if_ready` and `ls_ready` are never high together.

Test Plan:
1. Reset, then `if_req`=1, `if_addr`=0x100, memory returns 0x00000013 with zero wait → `mem_valid` high one cycle with `mem_addr`=0x100; `if_ready` pulses 2 cycles after the request is sampled with `if_rdata`=0x00000013.
2. `if_req` and `ls_req` (load 0x2000) asserted on the same cycle → LSU granted first; fetch granted on the following IDLE; streak=1 then 0.
3. `if_req` held high, LSU issues 5 back-to-back loads, MAX_LS_STREAK=4 → grant order LS,LS,LS,LS,IF,LS.
4. Store `ls_addr`=0x3000, `ls_wdata`=0xDEADBEEF, `ls_wmask`=4'b1100, 3 wait states → `mem_we`=1, `mem_wmask`=1100 held 4 cycles; `ls_ready` pulses; `ls_rdata` unchanged.
5. TIMEOUT=8, memory never ready → `mem_valid` drops after 8 BUSY cycles; `ls_ready` and `bus_err` pulse together; `ls_rdata`=0; `mem_ready` arriving on cycle 8 instead gives data and no `bus_err`.
6. Reset asserted during BUSY_LS → next cycle `mem_valid`=0, no `ls_ready`, state IDLE, streak=0; a pending `if_req` is granted after reset deasserts.
